// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared screen/ship constants, colour codes, bomb slot states and coordinate helpers
package space_invaders_pkg;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_SHIP_WIDTH    = 60;
  localparam int DEF_SHIP_HEIGHT   = 30;
  localparam int DEF_V_OFFSET      = 10;
  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] EXPLOSION  = 3'd1;
  localparam logic [2:0] LASER      = 3'd2;
  localparam logic [2:0] BOMB       = 3'd4;
  typedef enum logic [1:0] {IDLE, FALLING, HIT} slot_state_t;
  // Signed 11-bit difference so coordinates near 0 never wrap into large values
  function automatic logic signed [10:0] sdiff(input logic [9:0] a, input logic [9:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction
  function automatic logic in_span(input logic signed [10:0] d, input logic signed [10:0] half);
    return (d >= -half) && (d <= half);
  endfunction
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one falling bomb with its FSM, position, explosion timer, collision and pixel-in-box flags
module bomb_slot
  import space_invaders_pkg::*;
#(
  parameter int SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
  parameter int SHIP_WIDTH     = DEF_SHIP_WIDTH,
  parameter int SHIP_HEIGHT    = DEF_SHIP_HEIGHT,
  parameter int V_OFFSET       = DEF_V_OFFSET,
  parameter int BOMB_HALF_W    = 2,
  parameter int BOMB_HALF_H    = 6,
  parameter int STEP_MOTION    = 2,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        launch,
  input  logic [9:0]  launch_x,
  input  logic [9:0]  launch_y,
  input  logic [9:0]  gun_position,
  input  logic [9:0]  h_pos,
  input  logic [9:0]  v_pos,
  output slot_state_t state,
  output logic        hit,
  output logic        in_bomb,
  output logic        in_explode
);
  localparam int CW = $clog2(EXPLODE_FRAMES + 1);
  localparam logic [10:0] SHIP_TOP = 11'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT);
  localparam logic [9:0] OFF_Y = 10'(SCREEN_HEIGHT - BOMB_HALF_H);
  localparam logic signed [10:0] HIT_HALF = 11'(SHIP_WIDTH / 2 + BOMB_HALF_W - 1);
  localparam logic signed [10:0] BW = 11'(BOMB_HALF_W);
  localparam logic signed [10:0] EW = 11'(2 * BOMB_HALF_W);
  localparam logic signed [10:0] BH = 11'(BOMB_HALF_H);
  slot_state_t state_d;
  logic [9:0] x, y, x_d, y_d;
  logic [CW-1:0] cnt, cnt_d;
  logic collide, in_h_bomb, in_h_explode, in_v;
  // Collision tests the position held before this frame's move
  assign collide = (11'(y) + 11'(BOMB_HALF_H) >= SHIP_TOP) && in_span(sdiff(x, gun_position), HIT_HALF);
  assign in_h_bomb = in_span(sdiff(h_pos, x), BW);
  assign in_h_explode = in_span(sdiff(h_pos, x), EW);
  assign in_v = in_span(sdiff(v_pos, y), BH);
  // State, position and explosion timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      x     <= x_d;
      y     <= y_d;
      cnt   <= cnt_d;
    end
  end
  // Next state: launch loads position; frame tick moves, hits or retires the bomb
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    cnt_d   = cnt;
    if (launch) begin
      state_d = FALLING;
      x_d     = launch_x;
      y_d     = launch_y;
    end else if (enable && state == FALLING) begin
      if (collide) begin
        state_d = HIT;
        cnt_d   = CW'(EXPLODE_FRAMES);
      end else if (y >= OFF_Y) begin
        state_d = IDLE;
      end else begin
        y_d = y + 10'(STEP_MOTION);
      end
    end else if (enable && state == HIT) begin
      cnt_d = cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    end
  end
  // Outputs: collision pulse for this frame and pixel membership in bomb/explosion boxes
  always_comb begin
    hit        = enable && state == FALLING && collide;
    in_bomb    = state == FALLING && in_h_bomb && in_v;
    in_explode = state == HIT && in_h_explode && in_v;
  end
endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: pool of falling alien bombs with launch arbitration, cooldown, ship-hit pulse and pixel colour
module alien_bomb
  import space_invaders_pkg::*;
#(
  parameter int NUM_BOMBS      = 2,
  parameter int SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
  parameter int SHIP_WIDTH     = DEF_SHIP_WIDTH,
  parameter int SHIP_HEIGHT    = DEF_SHIP_HEIGHT,
  parameter int V_OFFSET       = DEF_V_OFFSET,
  parameter int BOMB_HALF_W    = 2,
  parameter int BOMB_HALF_H    = 6,
  parameter int STEP_MOTION    = 2,
  parameter int COOLDOWN       = 60,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 dropReq,
  input  logic [9:0]           dropX,
  input  logic [9:0]           dropY,
  input  logic [9:0]           gunPosition,
  input  logic [9:0]           hPos,
  input  logic [9:0]           vPos,
  output logic                 dropAck,
  output logic                 hitShip,
  output logic [NUM_BOMBS-1:0] bombsActive,
  output logic [2:0]           colorBomb
);
  localparam int CDW = $clog2(COOLDOWN + 1);
  slot_state_t state [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] idle, grant, hit, in_bomb, in_explode;
  logic [CDW-1:0] cooldown;
  logic launch;
  assign launch = dropReq && cooldown == '0 && |idle;
  assign grant = launch ? idle & (~idle + NUM_BOMBS'(1)) : '0;
  for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
    bomb_slot #(
      .SCREEN_HEIGHT(SCREEN_HEIGHT), .SHIP_WIDTH(SHIP_WIDTH), .SHIP_HEIGHT(SHIP_HEIGHT),
      .V_OFFSET(V_OFFSET), .BOMB_HALF_W(BOMB_HALF_W), .BOMB_HALF_H(BOMB_HALF_H),
      .STEP_MOTION(STEP_MOTION), .EXPLODE_FRAMES(EXPLODE_FRAMES)
    ) u_slot (
      .clk(clk), .reset_n(reset_n), .enable(enable), .launch(grant[i]),
      .launch_x(dropX), .launch_y(dropY), .gun_position(gunPosition),
      .h_pos(hPos), .v_pos(vPos), .state(state[i]),
      .hit(hit[i]), .in_bomb(in_bomb[i]), .in_explode(in_explode[i])
    );
    assign idle[i] = state[i] == IDLE;
    assign bombsActive[i] = state[i] != IDLE;
  end
  // Cooldown between launches; a reload on launch beats the frame decrement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cooldown <= '0;
    else if (launch) cooldown <= CDW'(COOLDOWN);
    else if (enable && cooldown != '0) cooldown <= cooldown - CDW'(1);
  end
  // Registered pulses and colour, explosion drawn over bombs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropAck   <= 1'b0;
      hitShip   <= 1'b0;
      colorBomb <= BACKGROUND;
    end else begin
      dropAck   <= launch;
      hitShip   <= |hit;
      colorBomb <= |in_explode ? EXPLOSION : |in_bomb ? BOMB : BACKGROUND;
    end
  end
endmodule

// File: tb/tb_alien_bomb.sv
// tb_alien_bomb: directed scoreboard bench for the alien bomb pool
module tb_alien_bomb;
  logic clk = 1'b0, reset_n, enable, dropReq;
  logic [9:0] dropX, dropY, gunPosition, hPos, vPos;
  logic dropAck, hitShip;
  logic [1:0] bombsActive;
  logic [2:0] colorBomb;
  int checks = 0, failures = 0, hits = 0, acks = 0;
  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t sb_q[$];
  alien_bomb dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dropReq(dropReq),
    .dropX(dropX), .dropY(dropY), .gunPosition(gunPosition), .hPos(hPos), .vPos(vPos),
    .dropAck(dropAck), .hitShip(hitShip), .bombsActive(bombsActive), .colorBomb(colorBomb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask
  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask
  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    #1;
    enable = 1'b0;
    if (hitShip) hits++;
    if (dropAck) acks++;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    dropReq = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hits = 0;
    acks = 0;
  endtask
  task automatic launch(input logic [9:0] x, input logic [9:0] y);
    dropX = x;
    dropY = y;
    dropReq = 1'b1;
    sb_push("launch_ack", 1);
    step(1'b0);
    sb_pop(32'(dropAck));
    dropReq = 1'b0;
  endtask
  initial begin
    logic [9:0] px [6] = '{10'd201, 10'd202, 10'd198, 10'd203, 10'd200, 10'd600};
    logic [9:0] py [6] = '{10'd205, 10'd206, 10'd194, 10'd200, 10'd207, 10'd50};
    logic [2:0] pc [6] = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
    reset_n = 1'b0; enable = 1'b0; dropReq = 1'b0; dropX = '0; dropY = '0;
    gunPosition = '0; hPos = '0; vPos = '0;
    #2;
    chk("rst_async_active", 32'(bombsActive), 0);
    do_reset();
    sb_push("rst_active", 0); sb_push("rst_ack", 0); sb_push("rst_hit", 0); sb_push("rst_color", 0);
    step(1'b0);
    sb_pop(32'(bombsActive)); sb_pop(32'(dropAck)); sb_pop(32'(hitShip)); sb_pop(32'(colorBomb));
    // hit: gun 320, bomb from (320,100)
    gunPosition = 10'd320;
    launch(10'd320, 10'd100);
    chk("hit_active", 32'(bombsActive), 1);
    sb_push("hit_ack_one", 0); step(1'b0); sb_pop(32'(dropAck));
    repeat (167) step(1'b1);
    hPos = 10'd320; vPos = 10'd440;
    sb_push("hit_y434_bottom", 4); step(1'b0); sb_pop(32'(colorBomb));
    vPos = 10'd441;
    sb_push("hit_y434_below", 0); step(1'b0); sb_pop(32'(colorBomb));
    chk("hit_none_early", 32'(hits), 0);
    sb_push("hit_pulse", 1); step(1'b1); sb_pop(32'(hitShip));
    chk("hit_state", 32'(bombsActive), 1);
    hPos = 10'd324; vPos = 10'd434;
    sb_push("hit_explode", 1); sb_push("hit_pulse_one", 0);
    step(1'b0); sb_pop(32'(colorBomb)); sb_pop(32'(hitShip));
    repeat (7) step(1'b1);
    chk("hit_still_exploding", 32'(bombsActive), 1);
    step(1'b1);
    chk("hit_idle", 32'(bombsActive), 0);
    chk("hit_count", 32'(hits), 1);
    // miss: gun 500, bomb from (100,100)
    hits = 0;
    gunPosition = 10'd500;
    launch(10'd100, 10'd100);
    repeat (187) step(1'b1);
    hPos = 10'd100; vPos = 10'd480;
    sb_push("miss_y474", 4); step(1'b0); sb_pop(32'(colorBomb));
    chk("miss_active", 32'(bombsActive), 1);
    step(1'b1);
    chk("miss_idle", 32'(bombsActive), 0);
    chk("miss_nohit", 32'(hits), 0);
    // pool/cooldown: request held high, enable every cycle
    do_reset();
    gunPosition = 10'd500; dropX = 10'd100; dropY = 10'd0; dropReq = 1'b1;
    sb_push("pool_launch0", 0); sb_push("pool_launch1", 61); sb_push("pool_launch2", 239);
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) begin
      step(1'b1);
      if (dropAck) sb_pop(32'(i));
    end
    while (sb_q.size() > 0) sb_pop(32'hFFFF_FFFF);
    dropReq = 1'b0;
    chk("pool_both_active", 32'(bombsActive), 3);
    chk("pool_ack_count", 32'(acks), 3);
    // signedness near the left edge
    do_reset();
    gunPosition = 10'd10;
    launch(10'd1000, 10'd400);
    repeat (40) step(1'b1);
    chk("edge_far_nohit", 32'(hits), 0);
    chk("edge_far_idle", 32'(bombsActive), 0);
    do_reset();
    launch(10'd0, 10'd400);
    repeat (17) step(1'b1);
    chk("edge_near_early", 32'(hits), 0);
    sb_push("edge_near_hit", 1); step(1'b1); sb_pop(32'(hitShip));
    // colour boxes around a falling bomb at (200,200)
    do_reset();
    launch(10'd200, 10'd200);
    for (int i = 0; i < 6; i++) begin
      hPos = px[i]; vPos = py[i];
      sb_push($sformatf("color_px%0d", i), 32'(pc[i]));
      step(1'b0);
      sb_pop(32'(colorBomb));
    end
    // explosion drawn over an overlapping falling bomb
    do_reset();
    gunPosition = 10'd320;
    launch(10'd320, 10'd312);
    repeat (60) step(1'b1);
    launch(10'd322, 10'd434);
    chk("overlap_active", 32'(bombsActive), 3);
    sb_push("overlap_hit", 1); step(1'b1); sb_pop(32'(hitShip));
    hPos = 10'd321; vPos = 10'd434;
    sb_push("overlap_color", 1); step(1'b0); sb_pop(32'(colorBomb));
    chk("overlap_one_falling", 32'(bombsActive), 3);
    hPos = 10'd330;
    sb_push("overlap_outside", 0); step(1'b0); sb_pop(32'(colorBomb));
    hPos = 10'd321;
    step(1'b0);
    // asynchronous reset mid-flight
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_color", 32'(colorBomb), 0);
    chk("midrst_active", 32'(bombsActive), 0);
    reset_n = 1'b1;
    dropX = 10'd50; dropY = 10'd50; dropReq = 1'b1;
    step(1'b0);
    chk("midrst_ack_before", 32'(dropAck), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(dropAck), 0);
    chk("midrst_hit", 32'(hitShip), 0);
    dropReq = 1'b0;
    reset_n = 1'b1;
    step(1'b0);
    chk("postrst_active", 32'(bombsActive), 0);
    chk("postrst_ack", 32'(dropAck), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
